jtag_cmd_seq: RTL

- Command sequencer in front of the JTAG shift engine (op/end_op/conf_op/len/work/busy control port).
- Accepts shift commands from a host over a valid/ready handshake.
- Checks that the instruction/data FIFOs hold enough payload, launches the engine, holds the control fields stable for the whole transaction, and reports completion, rejection or timeout per command.

---
 rtl/jtag_cmd_seq.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/jtag_cmd_seq.sv
// rtl/jtag_cmd_seq.sv - command sequencer in front of the JTAG shift engine
// Optional statistics outputs are enabled by defining JTAG_CMD_SEQ_STATS_EN.
module jtag_cmd_seq #(
   parameter int DATA_INSTRUCTION = 6,
   parameter int FIFO_DEPTH       = 16,
   parameter int LVL_W            = $clog2(FIFO_DEPTH + 1),
   parameter int TIMEOUT          = 4096
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_type,
   input  logic [7:0]       cmd_len,
   output logic             done,
   output logic [1:0]       err,
   output logic             seq_busy,
   output logic             op,
   output logic             end_op,
   output logic             conf_op,
   output logic [7:0]       len,
   output logic             work,
   input  logic             busy,
   input  logic             empty_instruction,
`ifdef JTAG_CMD_SEQ_STATS_EN
   output logic [15:0]      stat_ok,
   output logic [15:0]      stat_err,
   output logic [15:0]      stat_max_lat,
`endif
   input  logic [LVL_W-1:0] data_level
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_INIT, S_IDLE, S_CHECK, S_LAUNCH, S_WAIT_HI, S_WAIT_LO, S_DONE
   } state_t;

   state_t          state, state_nx;
   logic [1:0]      type_q;
   logic [7:0]      len_q;
   logic [1:0]      err_q, err_nx;
   logic [CW-1:0]   cnt;
   logic [8:0]      need_bytes;
   logic            len_bad, payload_ok, in_txn, timed_out;

   assign need_bytes = ({1'b0, len_q} + 9'd7) >> 3;
   assign len_bad    = ((type_q == 2'd1 || type_q == 2'd2) && len_q == 8'd0) ||
                       (type_q == 2'd1 && int'(len_q) > 8 * FIFO_DEPTH);
   assign timed_out  = (cnt == CW'(TIMEOUT - 1));

   always_comb begin
      payload_ok = 1'b1;
      case (type_q)
         2'd0:    payload_ok = !empty_instruction;
         2'd1:    payload_ok = int'(data_level) >= int'(need_bytes);
         default: payload_ok = 1'b1;
      endcase
   end

   // cnt equals the number of cycles since the launch cycle, so in S_DONE it is the latency
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_INIT;
         type_q <= 2'd0;
         len_q  <= 8'd0;
         err_q  <= 2'd0;
         cnt    <= '0;
      end else begin
         state <= state_nx;
         err_q <= err_nx;
         if (state == S_IDLE && cmd_valid) begin
            type_q <= cmd_type;
            len_q  <= cmd_len;
         end
         if (state == S_LAUNCH)
            cnt <= CW'(1);
         else if (state == S_WAIT_HI || state == S_WAIT_LO)
            cnt <= cnt + 1'b1;
      end
   end

   always_comb begin
      state_nx = state;
      err_nx   = err_q;
      case (state)
         S_INIT:    if (!busy) state_nx = S_IDLE;
         S_IDLE:    if (cmd_valid) state_nx = S_CHECK;
         S_CHECK: begin
            if (len_bad) begin
               state_nx = S_DONE;
               err_nx   = 2'd1;
            end else if (payload_ok && !busy) begin
               state_nx = S_LAUNCH;
            end
         end
         S_LAUNCH:  state_nx = S_WAIT_HI;
         S_WAIT_HI: begin
            if (timed_out) begin
               state_nx = S_DONE;
               err_nx   = 2'd2;
            end else if (busy) begin
               state_nx = S_WAIT_LO;
            end
         end
         // a falling busy wins over a timeout expiring in the same cycle
         S_WAIT_LO: begin
            if (!busy) begin
               state_nx = S_DONE;
               err_nx   = 2'd0;
            end else if (timed_out) begin
               state_nx = S_DONE;
               err_nx   = 2'd2;
            end
         end
         S_DONE:    state_nx = S_IDLE;
         default:   state_nx = S_INIT;
      endcase
   end

   assign in_txn    = (state == S_LAUNCH) || (state == S_WAIT_HI) || (state == S_WAIT_LO);
   assign cmd_ready = (state == S_IDLE);
   assign seq_busy  = (state == S_CHECK) || in_txn;
   assign done      = (state == S_DONE);
   assign err       = done ? err_q : 2'd0;
   assign work      = (state == S_LAUNCH);
   assign op        = in_txn && (type_q == 2'd1 || type_q == 2'd2);
   assign conf_op   = in_txn && (type_q == 2'd2);
   assign end_op    = in_txn && (type_q == 2'd3);
   assign len       = !in_txn          ? 8'd0 :
                      (type_q == 2'd0) ? 8'(DATA_INSTRUCTION) :
                      (type_q == 2'd3) ? 8'd0 : len_q;

   // the engine samples these fields continuously between work and busy falling
   a_fields_stable: assert property (@(posedge clk) disable iff (rst)
      (state == S_WAIT_HI || state == S_WAIT_LO) |-> ($stable(op) && $stable(conf_op) && $stable(len)));

`ifdef JTAG_CMD_SEQ_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_ok      <= 16'd0;
         stat_err     <= 16'd0;
         stat_max_lat <= 16'd0;
      end else if (state == S_DONE) begin
         if (err_q == 2'd0) begin
            if (stat_ok != 16'hFFFF) stat_ok <= stat_ok + 16'd1;
         end else begin
            if (stat_err != 16'hFFFF) stat_err <= stat_err + 16'd1;
         end
         if (err_q != 2'd1 && 16'(cnt) > stat_max_lat)
            stat_max_lat <= 16'(cnt);
      end
   end
`endif

endmodule
